// File: rtl/sevenseg_scanner.sv
// Time-multiplexed driver for a 4-digit common-anode seven-segment display.
// The displayed value is captured once per frame so a digit never tears mid-frame.
module sevenseg_scanner #(
  parameter int unsigned REFRESH_CYCLES = 100000,
  parameter bit          BLANK_LEADING  = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] hex,
  input  logic [3:0]  dp_in,
  input  logic        enable,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);

  localparam int unsigned CW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    d_q, d_d;
  logic [15:0]   shadow_hex_q, shadow_hex_d;
  logic [3:0]    shadow_dp_q, shadow_dp_d;
  logic [3:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;

  logic          slot_end;
  logic [1:0]    n;
  logic [3:0]    nib;
  logic          upper_live;
  logic          blank;

  function automatic logic [6:0] decode(input logic [3:0] v);
    case (v)
      4'h0: decode = 7'h40;
      4'h1: decode = 7'h79;
      4'h2: decode = 7'h24;
      4'h3: decode = 7'h30;
      4'h4: decode = 7'h19;
      4'h5: decode = 7'h12;
      4'h6: decode = 7'h02;
      4'h7: decode = 7'h78;
      4'h8: decode = 7'h00;
      4'h9: decode = 7'h10;
      4'hA: decode = 7'h08;
      4'hB: decode = 7'h03;
      4'hC: decode = 7'h46;
      4'hD: decode = 7'h21;
      4'hE: decode = 7'h06;
      default: decode = 7'h0E;
    endcase
  endfunction

  always_comb begin
    slot_end     = (cnt_q == CNT_LAST);
    n            = d_q + 2'd1;
    cnt_d        = slot_end ? '0 : cnt_q + CW'(1);
    d_d          = slot_end ? n : d_q;
    shadow_hex_d = shadow_hex_q;
    shadow_dp_d  = shadow_dp_q;
    if (slot_end && (d_q == 2'd3)) begin
      shadow_hex_d = hex;
      shadow_dp_d  = dp_in;
    end

    // Decisions use the next-slot digit and the freshly captured shadow value.
    nib        = 4'(shadow_hex_d >> {n, 2'b00});
    upper_live = ((shadow_hex_d >> {n, 2'b00}) != '0) || ((shadow_dp_d >> n) != '0);
    blank      = BLANK_LEADING && (n != 2'd0) && !upper_live;

    an_d  = an_q;
    seg_d = seg_q;
    dp_d  = dp_q;
    if (slot_end) begin
      if (!enable || blank) begin
        an_d  = '1;
        seg_d = '1;
        dp_d  = 1'b1;
      end else begin
        an_d  = ~(4'b0001 << n);
        seg_d = decode(nib);
        dp_d  = ~shadow_dp_d[n];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q        <= CNT_LAST;
      d_q          <= 2'd3;
      shadow_hex_q <= '0;
      shadow_dp_q  <= '0;
      an_q         <= '1;
      seg_q        <= '1;
      dp_q         <= 1'b1;
    end else begin
      cnt_q        <= cnt_d;
      d_q          <= d_d;
      shadow_hex_q <= shadow_hex_d;
      shadow_dp_q  <= shadow_dp_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = dp_q;

endmodule

// File: tb/tb_sevenseg_scanner.sv
// Bench for sevenseg_scanner: three configurations share one stimulus stream and are
// compared each cycle against a slot/frame arithmetic model, plus directed scenarios.
module tb_sevenseg_scanner;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] hex = 16'h0035;
  logic [3:0]  dp_in = 4'h0;
  logic        enable = 1'b1;

  logic [3:0] an_a, an_b, an_c;
  logic [6:0] seg_a, seg_b, seg_c;
  logic       dp_a, dp_b, dp_c;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  always #5 clk = ~clk;

  sevenseg_scanner #(.REFRESH_CYCLES(4), .BLANK_LEADING(1'b1)) dut_a (
    .clk(clk), .reset(reset), .hex(hex), .dp_in(dp_in), .enable(enable),
    .an(an_a), .seg(seg_a), .dp(dp_a));
  sevenseg_scanner #(.REFRESH_CYCLES(4), .BLANK_LEADING(1'b0)) dut_b (
    .clk(clk), .reset(reset), .hex(hex), .dp_in(dp_in), .enable(enable),
    .an(an_b), .seg(seg_b), .dp(dp_b));
  sevenseg_scanner #(.REFRESH_CYCLES(1), .BLANK_LEADING(1'b1)) dut_c (
    .clk(clk), .reset(reset), .hex(hex), .dp_in(dp_in), .enable(enable),
    .an(an_c), .seg(seg_c), .dp(dp_c));

  logic [6:0] SEG_TBL [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  int unsigned R  [3] = '{4, 4, 1};
  bit          BL [3] = '{1'b1, 1'b0, 1'b1};

  // Model: edge k after reset starts slot k/R when k%R==0; digit = slot%4.
  int unsigned edges [3];
  logic [15:0] sh    [3];
  logic [3:0]  sdp   [3];
  logic [3:0]  exp_an  [3];
  logic [6:0]  exp_seg [3];
  logic        exp_dp  [3];

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 3; i++) begin
        edges[i] = 0; sh[i] = 16'h0; sdp[i] = 4'h0;
        exp_an[i] = 4'hF; exp_seg[i] = 7'h7F; exp_dp[i] = 1'b1;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (edges[i] % R[i] == 0) begin
          int unsigned digit;
          int unsigned nibv;
          digit = (edges[i] / R[i]) % 4;
          if (digit == 0) begin
            sh[i] = hex;
            sdp[i] = dp_in;
          end
          nibv = (32'(sh[i]) >> (4 * digit)) & 15;
          if (!enable || (BL[i] && digit != 0 && (32'(sh[i]) >> (4 * digit)) == 0
                          && (32'(sdp[i]) >> digit) == 0)) begin
            exp_an[i] = 4'hF; exp_seg[i] = 7'h7F; exp_dp[i] = 1'b1;
          end else begin
            exp_an[i]  = 4'hF & ~(4'b0001 << digit);
            exp_seg[i] = SEG_TBL[nibv];
            exp_dp[i]  = ~sdp[i][digit];
          end
        end
        edges[i]++;
      end
    end
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
    vectors++;
    assert (obs === exp_v) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic chk_model();
    chk("a_an", 16'(an_a), 16'(exp_an[0]));
    chk("a_seg", 16'(seg_a), 16'(exp_seg[0]));
    chk("a_dp", 16'(dp_a), 16'(exp_dp[0]));
    chk("b_an", 16'(an_b), 16'(exp_an[1]));
    chk("b_seg", 16'(seg_b), 16'(exp_seg[1]));
    chk("b_dp", 16'(dp_b), 16'(exp_dp[1]));
    chk("c_an", 16'(an_c), 16'(exp_an[2]));
    chk("c_seg", 16'(seg_c), 16'(exp_seg[2]));
    chk("c_dp", 16'(dp_c), 16'(exp_dp[2]));
  endtask

  task automatic chk_dark(input string tag);
    chk({tag, "_an_a"}, 16'(an_a), 16'hF);
    chk({tag, "_seg_a"}, 16'(seg_a), 16'h7F);
    chk({tag, "_dp_a"}, 16'(dp_a), 16'h1);
    chk({tag, "_an_b"}, 16'(an_b), 16'hF);
    chk({tag, "_an_c"}, 16'(an_c), 16'hF);
    chk({tag, "_seg_c"}, 16'(seg_c), 16'h7F);
    chk({tag, "_dp_c"}, 16'(dp_c), 16'h1);
  endtask

  // Asserts reset between clock edges, checks the outputs go dark at once, releases.
  task automatic do_reset(input string tag);
    @(negedge clk);
    #2 reset = 1'b1;
    #1 chk_dark(tag);
    @(negedge clk);
    reset = 1'b0;
  endtask

  logic [3:0]  T1_AN  [4] = '{4'hE, 4'hD, 4'hF, 4'hF};
  logic [6:0]  T1_SEG [4] = '{7'h12, 7'h30, 7'h7F, 7'h7F};
  logic [3:0]  T2_AN  [4] = '{4'hE, 4'hD, 4'hB, 4'h7};
  logic [6:0]  T2_SEG [4] = '{7'h0E, 7'h40, 7'h03, 7'h08};
  logic [6:0]  T3_SEG [5] = '{7'h19, 7'h30, 7'h24, 7'h79, 7'h00};
  logic [3:0]  T4_AN  [4] = '{4'hE, 4'hD, 4'hB, 4'hF};
  logic [6:0]  T4_SEG [4] = '{7'h40, 7'h40, 7'h40, 7'h7F};
  logic        T4_DP  [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
  logic [3:0]  T5_AN  [6] = '{4'hE, 4'hD, 4'hB, 4'hF, 4'hE, 4'hD};
  logic [6:0]  T5_SEG [6] = '{7'h19, 7'h30, 7'h24, 7'h7F, 7'h19, 7'h30};
  logic [15:0] HMASK  [5] = '{16'hFFFF, 16'h0FFF, 16'h00FF, 16'h000F, 16'h0000};
  logic [3:0]  DMASK  [4] = '{4'hF, 4'h3, 4'h1, 4'h0};

  initial begin
    // Reset state while held.
    #12 chk_dark("rst_hold");

    // Leading-zero blanking on 0x0035.
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 32; c++) begin
      @(negedge clk);
      chk_model();
      chk("t1_an", 16'(an_a), 16'(T1_AN[(c / 4) % 4]));
      chk("t1_seg", 16'(seg_a), 16'(T1_SEG[(c / 4) % 4]));
    end

    // No blanking, all four digits of 0xAB0F.
    hex = 16'hAB0F;
    do_reset("t2_rst");
    for (int c = 0; c < 32; c++) begin
      @(negedge clk);
      chk_model();
      chk("t2_an", 16'(an_b), 16'(T2_AN[(c / 4) % 4]));
      chk("t2_seg", 16'(seg_b), 16'(T2_SEG[(c / 4) % 4]));
    end

    // Shadowing: a mid-frame change appears only at the next frame.
    hex = 16'h1234;
    do_reset("t3_rst");
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      chk_model();
      chk("t3_seg", 16'(seg_a), 16'(T3_SEG[c / 4]));
      if (c == 5) hex = 16'h5678;
    end

    // Zero value with a decimal point keeps digits up to the dp.
    hex = 16'h0000;
    dp_in = 4'b0100;
    do_reset("t4_rst");
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      chk_model();
      chk("t4_an", 16'(an_a), 16'(T4_AN[c / 4]));
      chk("t4_seg", 16'(seg_a), 16'(T4_SEG[c / 4]));
      chk("t4_dp", 16'(dp_a), 16'(T4_DP[c / 4]));
    end

    // Enable dropped mid-slot 2, restored before slot 4.
    hex = 16'h1234;
    dp_in = 4'h0;
    do_reset("t5_rst");
    for (int c = 0; c < 24; c++) begin
      @(negedge clk);
      chk_model();
      chk("t5_an", 16'(an_a), 16'(T5_AN[c / 4]));
      chk("t5_seg", 16'(seg_a), 16'(T5_SEG[c / 4]));
      if (c == 9) enable = 1'b0;
      if (c == 14) enable = 1'b1;
    end

    // REFRESH_CYCLES=1: async reset mid-slot, then one digit per clock.
    do_reset("t6_rst");
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      chk_model();
      chk("t6_an", 16'(an_c), 16'(T2_AN[c % 4]));
    end

    // Randomized traffic against the model.
    for (int c = 0; c < 800; c++) begin
      @(negedge clk);
      chk_model();
      if ($urandom % 11 == 0) hex = 16'($urandom) & HMASK[$urandom_range(0, 4)];
      if ($urandom % 17 == 0) dp_in = 4'($urandom) & DMASK[$urandom_range(0, 3)];
      if ($urandom % 29 == 0) enable = ~enable;
      if ($urandom % 211 == 0) begin
        #2 reset = 1'b1;
        #1 chk_dark("rnd_rst");
        @(negedge clk);
        reset = 1'b0;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
